// File: rtl/coin_event_ctrl.sv
// Drift-tube trigger/readout sequencer: synchronizes the coincidence and tube hits,
// collects hits over a fixed window and writes a three-word record to the readout FIFO.
module coin_event_ctrl #(
  parameter int WINDOW_CYCLES  = 20,
  parameter int HOLDOFF_CYCLES = 10
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        SCIN_COIN,
  input  logic [7:0]  TUBE3A,
  input  logic [7:0]  TUBE3B,
  input  logic [7:0]  TUBE4A,
  input  logic [7:0]  TUBE4B,
  input  logic        fifo_full,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        overflowLight,
  output logic        busy
);

  localparam logic [7:0] WIN_LOAD  = 8'(WINDOW_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES == 0) ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WINDOW, HDR, W3, W4, HOLD} state_t;

  state_t      state, state_n;
  logic        rst_meta, rst_sync;
  logic [2:0]  coin_s;
  logic        trig;
  logic [31:0] tube_s1, tube_s2, tube_s3;
  logic [31:0] acc, acc_n;
  logic [7:0]  win_cnt, win_n;
  logic [7:0]  hold_cnt, hold_n;
  logic [11:0] evt_cnt, evt_n;
  logic        wr_en_n, ovf_n;
  logic [15:0] wr_data_n;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // The extra tube stage keeps hit latency equal to the registered trigger path.
  always_ff @(posedge clk100 or posedge rst_sync) begin
    if (rst_sync) begin
      coin_s  <= 3'b000;
      trig    <= 1'b0;
      tube_s1 <= 32'h0;
      tube_s2 <= 32'h0;
      tube_s3 <= 32'h0;
    end else begin
      coin_s  <= {coin_s[1:0], SCIN_COIN};
      trig    <= coin_s[1] & ~coin_s[2];
      tube_s1 <= {TUBE3A, TUBE3B, TUBE4A, TUBE4B};
      tube_s2 <= tube_s1;
      tube_s3 <= tube_s2;
    end
  end

  always_ff @(posedge clk100 or posedge rst_sync) begin
    if (rst_sync) begin
      state         <= IDLE;
      acc           <= 32'h0;
      win_cnt       <= 8'd0;
      hold_cnt      <= 8'd0;
      evt_cnt       <= 12'd0;
      wr_en         <= 1'b0;
      wr_data       <= 16'h0;
      overflowLight <= 1'b0;
    end else begin
      state         <= state_n;
      acc           <= acc_n;
      win_cnt       <= win_n;
      hold_cnt      <= hold_n;
      evt_cnt       <= evt_n;
      wr_en         <= wr_en_n;
      wr_data       <= wr_data_n;
      overflowLight <= ovf_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    win_n     = win_cnt;
    hold_n    = hold_cnt;
    evt_n     = evt_cnt;
    wr_en_n   = 1'b0;
    wr_data_n = wr_data;
    ovf_n     = overflowLight;
    case (state)
      IDLE: begin
        if (trig) begin
          acc_n   = 32'h0;
          win_n   = WIN_LOAD;
          evt_n   = evt_cnt + 12'd1;
          state_n = WINDOW;
        end
      end
      WINDOW: begin
        acc_n = acc | tube_s3;
        if (win_cnt == 8'd0) state_n = HDR;
        else                 win_n   = win_cnt - 8'd1;
      end
      // A full FIFO at the header drops the whole event; later words only stall.
      HDR: begin
        if (!fifo_full) begin
          wr_en_n   = 1'b1;
          wr_data_n = {4'hE, evt_cnt};
          state_n   = W3;
        end else begin
          ovf_n   = 1'b1;
          hold_n  = HOLD_LOAD;
          state_n = HOLD;
        end
      end
      W3: begin
        if (!fifo_full) begin
          wr_en_n   = 1'b1;
          wr_data_n = acc[31:16];
          state_n   = W4;
        end
      end
      W4: begin
        if (!fifo_full) begin
          wr_en_n   = 1'b1;
          wr_data_n = acc[15:0];
          hold_n    = HOLD_LOAD;
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == 8'd0) state_n = IDLE;
        else                  hold_n  = hold_cnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_event_ctrl.sv
// Directed bench for coin_event_ctrl: basic record, window edges, retrigger,
// FIFO-full drop and stall, and reset mid-window.
module tb_coin_event_ctrl;

  logic        clk100 = 1'b0;
  logic        reset = 1'b1;
  logic        SCIN_COIN = 1'b0;
  logic [7:0]  TUBE3A = 8'h0, TUBE3B = 8'h0, TUBE4A = 8'h0, TUBE4B = 8'h0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        overflowLight;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int k;
  logic [15:0] wq[$];
  int          wc[$];

  coin_event_ctrl #(.WINDOW_CYCLES(20), .HOLDOFF_CYCLES(10)) dut (
    .clk100(clk100), .reset(reset), .SCIN_COIN(SCIN_COIN),
    .TUBE3A(TUBE3A), .TUBE3B(TUBE3B), .TUBE4A(TUBE4A), .TUBE4B(TUBE4B),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .overflowLight(overflowLight), .busy(busy)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) cyc++;

  // Every FIFO write is logged with the cycle it was presented in.
  always @(negedge clk100) begin
    if (wr_en === 1'b1) begin
      wq.push_back(wr_data);
      wc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input int i);
    if (i < wq.size()) return wq[i];
    return 16'hxxxx;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < wc.size()) return wc[i];
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(5);
    wq.delete();
    wc.delete();
  endtask

  initial begin
    // Reset state
    tick(2);
    check_output("rst_wr_en", 32'(wr_en), 32'h0);
    check_output("rst_wr_data", 32'(wr_data), 32'h0);
    check_output("rst_overflow", 32'(overflowLight), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(5);
    wq.delete();
    wc.delete();

    // Basic event
    SCIN_COIN = 1'b1; tick(1); k = cyc;
    tick(2); TUBE3A = 8'h10;
    check_output("t1_busy_pre", 32'(busy), 32'h0);
    tick(1);
    check_output("t1_busy_start", 32'(busy), 32'h1);
    tick(3); TUBE3A = 8'h00;
    tick(3); SCIN_COIN = 1'b0;
    tick(5); TUBE4B = 8'h01;
    tick(4); TUBE4B = 8'h00;
    tick(17);
    check_output("t1_busy_hold", 32'(busy), 32'h1);
    tick(1);
    check_output("t1_busy_end", 32'(busy), 32'h0);
    check_output("t1_count", 32'(wq.size()), 32'd3);
    check_output("t1_hdr", 32'(word_at(0)), 32'hE001);
    check_output("t1_w3", 32'(word_at(1)), 32'h1000);
    check_output("t1_w4", 32'(word_at(2)), 32'h0001);
    check_output("t1_hdr_cycle", 32'(cyc_at(0) - k), 32'd24);
    check_output("t1_w4_cycle", 32'(cyc_at(2) - k), 32'd26);
    check_output("t1_overflow", 32'(overflowLight), 32'h0);

    // Hits outside the window
    apply_reset();
    TUBE3A = 8'h10; tick(3); TUBE3A = 8'h00; tick(5);
    SCIN_COIN = 1'b1; tick(1); k = cyc;
    tick(9); SCIN_COIN = 1'b0;
    tick(15); TUBE3B = 8'h08;
    tick(4); TUBE3B = 8'h00;
    tick(20);
    check_output("t2_count", 32'(wq.size()), 32'd3);
    check_output("t2_hdr", 32'(word_at(0)), 32'hE001);
    check_output("t2_w3", 32'(word_at(1)), 32'h0000);
    check_output("t2_w4", 32'(word_at(2)), 32'h0000);

    // Retrigger rejection: edges in WINDOW and HOLD ignored, level across IDLE ignored
    apply_reset();
    SCIN_COIN = 1'b1; tick(1); k = cyc;
    tick(9);  SCIN_COIN = 1'b0;
    tick(3);  SCIN_COIN = 1'b1;
    tick(3);  SCIN_COIN = 1'b0;
    tick(12); SCIN_COIN = 1'b1;
    tick(13); SCIN_COIN = 1'b0;
    tick(5);  SCIN_COIN = 1'b1;
    tick(10); SCIN_COIN = 1'b0;
    tick(50);
    check_output("t3_count", 32'(wq.size()), 32'd6);
    check_output("t3_hdr1", 32'(word_at(0)), 32'hE001);
    check_output("t3_hdr2", 32'(word_at(3)), 32'hE002);
    check_output("t3_hdr2_cycle", 32'(cyc_at(3) - k), 32'd70);

    // FIFO full at header drops the event
    apply_reset();
    fifo_full = 1'b1;
    SCIN_COIN = 1'b1; tick(1); k = cyc;
    tick(9); SCIN_COIN = 1'b0;
    tick(20);
    check_output("t4_overflow", 32'(overflowLight), 32'h1);
    fifo_full = 1'b0;
    tick(10);
    check_output("t4_busy", 32'(busy), 32'h0);
    check_output("t4_no_writes", 32'(wq.size()), 32'd0);
    SCIN_COIN = 1'b1; tick(10); SCIN_COIN = 1'b0;
    tick(40);
    check_output("t4_count", 32'(wq.size()), 32'd3);
    check_output("t4_hdr", 32'(word_at(0)), 32'hE002);
    check_output("t4_overflow_sticky", 32'(overflowLight), 32'h1);

    // FIFO full for 5 cycles starting at W3 stalls without dropping
    apply_reset();
    TUBE3B = 8'hA5; TUBE4A = 8'h3C;
    SCIN_COIN = 1'b1; tick(1); k = cyc;
    tick(9); SCIN_COIN = 1'b0;
    tick(15); fifo_full = 1'b1;
    tick(5);  fifo_full = 1'b0;
    tick(20);
    TUBE3B = 8'h00; TUBE4A = 8'h00;
    check_output("t5_count", 32'(wq.size()), 32'd3);
    check_output("t5_hdr", 32'(word_at(0)), 32'hE001);
    check_output("t5_w3", 32'(word_at(1)), 32'h00A5);
    check_output("t5_w4", 32'(word_at(2)), 32'h3C00);
    check_output("t5_hdr_cycle", 32'(cyc_at(0) - k), 32'd24);
    check_output("t5_w3_cycle", 32'(cyc_at(1) - k), 32'd30);
    check_output("t5_w4_cycle", 32'(cyc_at(2) - k), 32'd31);
    check_output("t5_overflow", 32'(overflowLight), 32'h0);

    // Reset in WINDOW aborts at once; count restarts
    apply_reset();
    SCIN_COIN = 1'b1; tick(1); k = cyc;
    tick(9); SCIN_COIN = 1'b0;
    check_output("t6_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check_output("t6_busy", 32'(busy), 32'h0);
    check_output("t6_wr_en", 32'(wr_en), 32'h0);
    check_output("t6_wr_data", 32'(wr_data), 32'h0);
    check_output("t6_overflow", 32'(overflowLight), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    wq.delete();
    wc.delete();
    SCIN_COIN = 1'b1; tick(10); SCIN_COIN = 1'b0;
    tick(40);
    check_output("t6_count", 32'(wq.size()), 32'd3);
    check_output("t6_hdr", 32'(word_at(0)), 32'hE001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coin_event_ctrl.md
# coin_event_ctrl

Trigger and readout sequencer for the drift-tube event path, clocked by clk100. Synchronizes the scintillator coincidence and the four 8-bit tube layers, and opens a fixed hit-collection window on each accepted coincidence. At window close it writes a three-word event record (header plus two hit words) into the readout FIFO write port, then applies a holdoff. It owns the sticky overflow indicator that drives overflowLight.

## Interface
- WINDOW_CYCLES, 20, length of hit-collection window in clk100 cycles (200 ns); legal range 1..255
- HOLDOFF_CYCLES, 10, dead time after the last record word before the next trigger is accepted; legal range 0..255
- clk100  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- SCIN_COIN  in  1  scintillator coincidence, asynchronous to clk100
- TUBE3A, TUBE3B, TUBE4A, TUBE4B  in  8 each  tube hit lines, asynchronous, level-high = hit
- fifo_full  in  1  readout FIFO write-side full flag, synchronous to clk100
- wr_en  out  1  FIFO write strobe, one cycle per word
- wr_data  out  16  FIFO write data, valid when wr_en=1
- overflowLight  out  1  sticky: at least one event dropped since reset
- busy  out  1  high in every state except IDLE

## Operation
- Input sync:
  - SCIN_COIN and all 32 tube bits pass through 2-flop synchronizers.
  - Rising-edge detect on synced SCIN_COIN: trig = s2 & ~s3.
- State machine: IDLE, WINDOW, HDR, W3, W4, HOLD.
- IDLE:
  - On trig, clear the 32-bit hit accumulator and load the window counter with WINDOW_CYCLES-1.
  - evt_cnt (12 bits) increments on every accepted trig, wrapping 4095 to 0.
  - Next state is WINDOW.
- WINDOW:
  - Each cycle, accumulator |= synced {TUBE3A,TUBE3B,TUBE4A,TUBE4B}.
  - Counter decrements; at 0, go to HDR after exactly WINDOW_CYCLES cycles in WINDOW.
- HDR:
  - If fifo_full=0: wr_en=1, wr_data={4'hE, evt_cnt of this event}, next state W3.
  - If fifo_full=1: the whole event is dropped. No write, overflowLight set, next state HOLD.
- W3:
  - Write {TUBE3A,TUBE3B} accumulator bits, next state W4.
  - If fifo_full=1, stall in W3 with wr_en=0 and data held; do not drop.
- W4: write {TUBE4A,TUBE4B} accumulator bits with the same stall rule, then load holdoff, next state HOLD.
- HOLD:
  - Stay HOLDOFF_CYCLES cycles; with 0, return to IDLE on the next cycle.
  - Return to IDLE.
- Triggers outside IDLE are ignored and not counted.
  - A coincidence still high on the return to IDLE produces no new edge.
- Bit order: TUBE3A[7] is wr_data[15] of word W3; TUBE4B[0] is wr_data[0] of word W4.
- overflowLight is cleared only by reset.

## Timing
- Reset (async assert, sync release): state IDLE, wr_en=0, wr_data=0, overflowLight=0, busy=0, evt_cnt=0, accumulator=0, synchronizers=0.
- Reset mid-operation aborts immediately. A partially written record is not completed; the FIFO owner handles the truncated record.
- Trigger latency:
  - SCIN_COIN first sampled high at edge k: trig is high in the cycle after edge k+2.
  - WINDOW begins at edge k+3, and busy=1 from edge k+3.
- A tube pulse is captured if its synced value is high in any WINDOW cycle. Tube and coincidence paths have equal synchronizer latency.
- With fifo_full=0 throughout: HDR, W3 and W4 occupy 3 consecutive cycles, giving wr_en high for 3 back-to-back cycles.
- Minimum trigger-to-trigger spacing: WINDOW_CYCLES+3+HOLDOFF_CYCLES+1 cycles.
- wr_en and wr_data are registered outputs. fifo_full is sampled in the same cycle the write would occur.

## Test plan
- Basic event:
  - Stimulus: SCIN_COIN high 100 ns; TUBE3A=8'h10 30 ns after the edge; TUBE4B=8'h01 150 ns after; fifo_full=0.
  - Required: exactly 3 writes, 16'hE001, 16'h1000, 16'h0001; busy falls after holdoff.
- Hit outside window:
  - Stimulus: TUBE3A=8'h10 pulse ending before SCIN_COIN, plus TUBE3B=8'h08 250 ns after the edge.
  - Required: record words 16'hE001, 16'h0000, 16'h0000.
- Retrigger rejection:
  - Stimulus: second SCIN_COIN edge during WINDOW, then one during HOLD, then one after IDLE.
  - Required: only 2 records, with headers 16'hE001 and 16'hE002.
- FIFO full at header:
  - Stimulus: fifo_full=1 through HDR.
  - Required: no wr_en pulses and overflowLight=1. The next event, with fifo_full=0, has header 16'hE002, so the gap in the count is visible.
- FIFO full mid-record: fifo_full=1 for 5 cycles starting at W3 -> wr_en low for exactly those 5 cycles, then words W3 and W4 are written intact; overflowLight stays 0.
- Reset mid-window: reset asserted in WINDOW -> all outputs 0 immediately; the next event header is 16'hE001.
